// File: rtl/icache_ram_pkg.sv
// Shared types and sizes for the icache data SRAM arbiter.
package icache_ram_pkg;

    localparam int ICACHE_RAM_ADDR_W = 5;
    localparam int ICACHE_RAM_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/icache_ram_rd_hold.sv
// One-cycle read-valid pipe plus hold register; the SRAM drives dout to X after each posedge,
// so data is passed through in the valid cycle and latched for the cycles that follow.
module icache_ram_rd_hold
    import icache_ram_pkg::*;
#(
    parameter int DATA_WIDTH = ICACHE_RAM_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_issue_i,
    input  logic                  fwd_sel_i,
    input  logic [DATA_WIDTH-1:0] fwd_data_i,
    input  logic [DATA_WIDTH-1:0] ram_dout_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic                  valid_q,    valid_d;
    logic                  fwd_q,      fwd_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] hold_q,     hold_d;

    always_comb begin
        valid_d    = rd_issue_i;
        fwd_d      = rd_issue_i & fwd_sel_i;
        fwd_data_d = fwd_sel_i ? fwd_data_i : fwd_data_q;
        rd_data_o  = hold_q;
        if (valid_q) begin
            rd_data_o = fwd_q ? fwd_data_q : ram_dout_i;
        end
        hold_d     = rd_data_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            hold_q     <= hold_d;
        end
    end

    assign rd_valid_o = valid_q;

endmodule

// File: rtl/icache_data_ram_arb.sv
// Arbiter/flush sequencer for the 1W1R icache data SRAM.
// Optional same-address write-to-read forwarding: define ICACHE_RAM_ARB_FWD_EN.
//
//   state    | meaning
//   ST_IDLE  | serve fetch reads and refill writes
//   ST_FLUSH | one FLUSH_VALUE write per cycle, address = flush counter
//   ST_DONE  | single cycle, flush_done_o asserted
module icache_data_ram_arb
    import icache_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ICACHE_RAM_ADDR_W,
    parameter int                    DATA_WIDTH  = ICACHE_RAM_DATA_W,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_accept_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_accept_o,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    output logic                  flush_done_o,
    output logic                  ram_csb0_o,
    output logic [ADDR_WIDTH-1:0] ram_addr0_o,
    output logic [DATA_WIDTH-1:0] ram_din0_o,
    output logic                  ram_csb1_o,
    output logic [ADDR_WIDTH-1:0] ram_addr1_o,
    input  logic [DATA_WIDTH-1:0] ram_dout1_i
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  collide;
    logic                  fwd_sel;

    assign collide = wr_req_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_accept_o  = 1'b0;
        wr_accept_o  = 1'b0;
        flush_busy_o = 1'b0;
        flush_done_o = 1'b0;
        ram_csb0_o   = 1'b1;
        ram_addr0_o  = '0;
        ram_din0_o   = '0;
        ram_csb1_o   = 1'b1;
        ram_addr1_o  = '0;
        fwd_sel      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req_i) begin
                    wr_accept_o = 1'b1;
                    ram_csb0_o  = 1'b0;
                    ram_addr0_o = wr_addr_i;
                    ram_din0_o  = wr_data_i;
                end
                if (rd_req_i) begin
                    if (!collide) begin
                        rd_accept_o = 1'b1;
                        ram_csb1_o  = 1'b0;
                        ram_addr1_o = rd_addr_i;
                    end
`ifdef ICACHE_RAM_ARB_FWD_EN
                    else begin
                        // serve from the write bus; the array is not read
                        rd_accept_o = 1'b1;
                        fwd_sel     = 1'b1;
                    end
`endif
                end
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_busy_o = 1'b1;
                ram_csb0_o   = 1'b0;
                ram_addr0_o  = cnt_q;
                ram_din0_o   = FLUSH_VALUE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    icache_ram_rd_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_hold (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_issue_i (rd_accept_o),
        .fwd_sel_i  (fwd_sel),
        .fwd_data_i (wr_data_i),
        .ram_dout_i (ram_dout1_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o)
    );

endmodule

// File: tb/tb_icache_data_ram_arb.sv
// Directed bench for icache_data_ram_arb with a behavioural 32x64 1W1R SRAM model.
module tb_icache_data_ram_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rd_req_i;
    logic [4:0]  rd_addr_i;
    logic        rd_accept_o;
    logic        rd_valid_o;
    logic [63:0] rd_data_o;
    logic        wr_req_i;
    logic [4:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        wr_accept_o;
    logic        flush_i;
    logic        flush_busy_o;
    logic        flush_done_o;
    logic        ram_csb0_o;
    logic [4:0]  ram_addr0_o;
    logic [63:0] ram_din0_o;
    logic        ram_csb1_o;
    logic [4:0]  ram_addr1_o;
    logic [63:0] ram_dout1_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    icache_data_ram_arb dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_accept_o  (rd_accept_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .wr_req_i     (wr_req_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_accept_o  (wr_accept_o),
        .flush_i      (flush_i),
        .flush_busy_o (flush_busy_o),
        .flush_done_o (flush_done_o),
        .ram_csb0_o   (ram_csb0_o),
        .ram_addr0_o  (ram_addr0_o),
        .ram_din0_o   (ram_din0_o),
        .ram_csb1_o   (ram_csb1_o),
        .ram_addr1_o  (ram_addr1_o),
        .ram_dout1_i  (ram_dout1_i)
    );

    // SRAM model: sample at posedge, access array at negedge, dout invalid shortly after posedge
    logic [63:0] mem [32];
    logic        s_csb0, s_csb1;
    logic [4:0]  s_addr0, s_addr1;
    logic [63:0] s_din0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'h5555_0000_0000_0000 | 64'(i);
        s_csb0 = 1'b1;
        s_csb1 = 1'b1;
        s_addr0 = '0;
        s_addr1 = '0;
        s_din0 = '0;
        ram_dout1_i = '0;
    end

    always @(posedge clk_i) begin
        s_csb0  = ram_csb0_o;
        s_addr0 = ram_addr0_o;
        s_din0  = ram_din0_o;
        s_csb1  = ram_csb1_o;
        s_addr1 = ram_addr1_o;
        #1 ram_dout1_i = 'x;
    end

    always @(negedge clk_i) begin
        if (!s_csb0) mem[s_addr0] = s_din0;
        if (!s_csb1) ram_dout1_i = mem[s_addr1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive inputs just after posedge, return at the sampling point (posedge + 7)
    task automatic drive(input logic rd, input logic [4:0] ra, input logic wr,
                         input logic [4:0] wa, input logic [63:0] wd, input logic fl);
        @(posedge clk_i);
        #1;
        rd_req_i  = rd;
        rd_addr_i = ra;
        wr_req_i  = wr;
        wr_addr_i = wa;
        wr_data_i = wd;
        flush_i   = fl;
        #6;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    localparam logic [63:0] D3 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D7 = 64'hA7A7_A7A7_1234_5678;

    int  busy_cnt;
    bit  done_seen;

    initial begin
        rst_i = 1'b1;
        rd_req_i = 1'b0; rd_addr_i = '0;
        wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        flush_i = 1'b0;

        idle();
        check("rst_csb0", 64'(ram_csb0_o), 64'd1);
        check("rst_csb1", 64'(ram_csb1_o), 64'd1);
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_data", rd_data_o, 64'd0);
        check("rst_busy", 64'(flush_busy_o), 64'd0);
        check("rst_done", 64'(flush_done_o), 64'd0);

        @(posedge clk_i); #1 rst_i = 1'b0;

        drive(1'b0, 5'd0, 1'b1, 5'd2, 64'h2222_2222_2222_2222, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 5'd3, D3, 1'b0);
        check("w3_acc", 64'(wr_accept_o), 64'd1);
        check("w3_csb0", 64'(ram_csb0_o), 64'd0);
        check("w3_addr0", 64'(ram_addr0_o), 64'd3);
        check("w3_din0", ram_din0_o, D3);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b0);
        check("r3_acc", 64'(rd_accept_o), 64'd1);
        check("r3_csb1", 64'(ram_csb1_o), 64'd0);
        check("r3_addr1", 64'(ram_addr1_o), 64'd3);
        check("r3_nvalid", 64'(rd_valid_o), 64'd0);
        idle();
        check("r3_valid", 64'(rd_valid_o), 64'd1);
        check("r3_data", rd_data_o, D3);
        idle();
        check("r3_valid_end", 64'(rd_valid_o), 64'd0);
        check("r3_hold1", rd_data_o, D3);
        idle();
        check("r3_hold2", rd_data_o, D3);

        // same-address collision
        drive(1'b1, 5'd7, 1'b1, 5'd7, D7, 1'b0);
        check("c7_wacc", 64'(wr_accept_o), 64'd1);
        check("c7_csb1", 64'(ram_csb1_o), 64'd1);
`ifdef ICACHE_RAM_ARB_FWD_EN
        check("c7_racc_fwd", 64'(rd_accept_o), 64'd1);
        idle();
        check("c7_fwd_valid", 64'(rd_valid_o), 64'd1);
        check("c7_fwd_data", rd_data_o, D7);
`else
        check("c7_racc_stall", 64'(rd_accept_o), 64'd0);
        idle();
        check("c7_no_valid", 64'(rd_valid_o), 64'd0);
        check("c7_hold", rd_data_o, D3);
        drive(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0);
        check("c7_retry_acc", 64'(rd_accept_o), 64'd1);
        idle();
        check("c7_retry_valid", 64'(rd_valid_o), 64'd1);
        check("c7_retry_data", rd_data_o, D7);
`endif
        idle();

        // different addresses in the same cycle
        drive(1'b1, 5'd2, 1'b1, 5'd1, 64'h1111_1111_1111_1111, 1'b0);
        check("d12_wacc", 64'(wr_accept_o), 64'd1);
        check("d12_racc", 64'(rd_accept_o), 64'd1);
        check("d12_csb0", 64'(ram_csb0_o), 64'd0);
        check("d12_csb1", 64'(ram_csb1_o), 64'd0);
        idle();
        check("d12_valid", 64'(rd_valid_o), 64'd1);
        check("d12_data", rd_data_o, 64'h2222_2222_2222_2222);

        // flush with a read in the same IDLE cycle
        drive(1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b1);
        check("fl_rd_acc", 64'(rd_accept_o), 64'd1);
        check("fl_busy0", 64'(flush_busy_o), 64'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'd5, 1'b1, 5'd6, 64'hFFFF, 1'b1);
            check($sformatf("fl_busy_%0d", i), 64'(flush_busy_o), 64'd1);
            check($sformatf("fl_racc_%0d", i), 64'(rd_accept_o), 64'd0);
            check($sformatf("fl_wacc_%0d", i), 64'(wr_accept_o), 64'd0);
            check($sformatf("fl_csb0_%0d", i), 64'(ram_csb0_o), 64'd0);
            check($sformatf("fl_addr0_%0d", i), 64'(ram_addr0_o), 64'(i));
            check($sformatf("fl_din0_%0d", i), ram_din0_o, 64'd0);
            check($sformatf("fl_csb1_%0d", i), 64'(ram_csb1_o), 64'd1);
            if (i == 0) begin
                check("fl_rd_valid", 64'(rd_valid_o), 64'd1);
                check("fl_rd_data", rd_data_o, D3);
            end
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        check("fl_done", 64'(flush_done_o), 64'd1);
        check("fl_done_busy", 64'(flush_busy_o), 64'd0);
        idle();
        check("fl_done_end", 64'(flush_done_o), 64'd0);
        check("fl_no_restart", 64'(flush_busy_o), 64'd0);
        drive(1'b1, 5'd31, 1'b0, 5'd0, 64'd0, 1'b0);
        check("r31_acc", 64'(rd_accept_o), 64'd1);
        idle();
        check("r31_valid", 64'(rd_valid_o), 64'd1);
        check("r31_data", rd_data_o, 64'd0);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b0);
        idle();
        check("r3_flushed", rd_data_o, 64'd0);

        // reset while a read is in flight
        drive(1'b0, 5'd0, 1'b1, 5'd4, 64'h4444, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 5'd0, 64'd0, 1'b0);
        check("rr_acc", 64'(rd_accept_o), 64'd1);
        #1 rst_i = 1'b1;
        idle();
        check("rr_no_valid", 64'(rd_valid_o), 64'd0);
        check("rr_data_rst", rd_data_o, 64'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // reset in the middle of a sweep
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        for (int i = 0; i < 11; i++) idle();
        check("mr_addr0", 64'(ram_addr0_o), 64'd10);
        check("mr_busy", 64'(flush_busy_o), 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("mr_csb0", 64'(ram_csb0_o), 64'd1);
        check("mr_addr0_rst", 64'(ram_addr0_o), 64'd0);
        check("mr_busy_rst", 64'(flush_busy_o), 64'd0);
        check("mr_done_rst", 64'(flush_done_o), 64'd0);
        idle();
        check("mr_done_hold", 64'(flush_done_o), 64'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        idle();
        check("mr_done_after", 64'(flush_done_o), 64'd0);
        check("mr_busy_after", 64'(flush_busy_o), 64'd0);

        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        busy_cnt  = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (flush_busy_o === 1'b1) busy_cnt++;
            if (flush_done_o === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
        end
        check("sw2_busy_cycles", 64'(busy_cnt), 64'd32);
        check("sw2_done_seen", 64'(done_seen), 64'd1);
        idle();
        check("sw2_idle", 64'(flush_busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_data_ram_arb.md
Name: icache_data_ram_arb

Overview:
- Sequencer/arbiter in front of the 1W1R icache data SRAM (32 x 64, active-low chip selects, inputs sampled at posedge, array access at negedge).
- Shares the SRAM between the fetch read requester, the refill write requester and an internal flush sweep.
- Prevents same-address read/write collisions and holds read data stable, because the SRAM drives dout to X after every posedge.

Parameters:
- ADDR_WIDTH, 5, SRAM word-address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, SRAM word width.
- FLUSH_VALUE, 0, DATA_WIDTH-bit word written to every entry during flush.

Ports:
- clk_i  in  1  clock; also drives both SRAM clocks.
- rst_i  in  1  asynchronous, active-high reset.
- rd_req_i  in  1  fetch read request.
- rd_addr_i  in  ADDR_WIDTH  fetch read address.
- rd_accept_o  out  1  read granted this cycle.
- rd_valid_o  out  1  one-cycle pulse: rd_data_o updated.
- rd_data_o  out  DATA_WIDTH  held read data.
- wr_req_i  in  1  refill write request.
- wr_addr_i  in  ADDR_WIDTH  refill address.
- wr_data_i  in  DATA_WIDTH  refill data.
- wr_accept_o  out  1  write granted this cycle.
- flush_i  in  1  start flush; single-cycle pulse.
- flush_busy_o  out  1  flush sweep in progress.
- flush_done_o  out  1  one-cycle pulse after the last flush write.
- ram_csb0_o  out  1  SRAM write-port chip select, active low.
- ram_addr0_o  out  ADDR_WIDTH  SRAM write address.
- ram_din0_o  out  DATA_WIDTH  SRAM write data.
- ram_csb1_o  out  1  SRAM read-port chip select, active low.
- ram_addr1_o  out  ADDR_WIDTH  SRAM read address.
- ram_dout1_i  in  DATA_WIDTH  SRAM read data; valid only in the cycle after the read is issued.

Behaviour:
- Reset values:
  - ram_csb0_o = 1 and ram_csb1_o = 1.
  - All other outputs 0; rd_data_o = 0.
  - FSM in IDLE; flush counter = 0.
- SRAM port drive: all ram_* outputs are combinational from the grant decision.
  - A write granted in cycle k sets ram_csb0_o = 0 in cycle k.
  - A read granted in cycle k sets ram_csb1_o = 0 in cycle k.
  - The SRAM samples both at the posedge ending cycle k.
- Read latency:
  - Read accepted in cycle k -> rd_valid_o = 1 in cycle k+1.
  - In cycle k+1, rd_data_o = ram_dout1_i, captured through a hold register.
  - rd_data_o holds its value until the next rd_valid_o pulse.
- FSM states:
  - IDLE -> FLUSH on flush_i = 1.
  - FLUSH -> DONE when flush counter = 2**ADDR_WIDTH - 1 and that write issues.
  - DONE -> IDLE unconditionally after one cycle; flush_done_o = 1 while in DONE.
- IDLE arbitration:
  - The write is granted whenever wr_req_i = 1.
  - The read is granted when rd_req_i = 1 and not (wr_req_i && wr_addr_i == rd_addr_i).
  - On an address collision the read is stalled one cycle (rd_accept_o = 0) and retried by the requester.
  - A read and a write to different addresses are both granted in the same cycle.
- FLUSH state:
  - One write per cycle: address = counter, data = FLUSH_VALUE.
  - Counter increments by 1 and returns to 0 on exit; counter width is ADDR_WIDTH, no wrap beyond the last entry.
  - rd_accept_o = 0, wr_accept_o = 0, flush_busy_o = 1.
  - A sweep takes 2**ADDR_WIDTH cycles.
- flush_i during FLUSH or DONE is ignored (no restart).
- flush_i and a request in the same IDLE cycle: the request is served that cycle; FLUSH starts the next cycle.
- A read granted in the last IDLE cycle still delivers rd_valid_o in the first FLUSH cycle.
- Reset mid-flush: FSM returns to IDLE, counter = 0, no flush_done_o pulse; the SRAM is left partially flushed.
- Reset between a read grant and its rd_valid_o: the rd_valid_o pulse is suppressed.

Optional Feature:
- Macro: ICACHE_RAM_ARB_FWD_EN.
- Defined: on an IDLE same-address collision the read is granted with rd_accept_o = 1.
  - SRAM read port stays idle (ram_csb1_o = 1).
  - wr_data_i is registered; the next cycle gives rd_valid_o = 1 and rd_data_o = that forwarded write data.
- Undefined: the stall behaviour above.

Decomposition:
- Package icache_ram_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_FLUSH, ST_DONE, 2 bits);
  - ICACHE_RAM_ADDR_W = 5 and ICACHE_RAM_DATA_W = 64.
- Sub-module icache_ram_rd_hold: 1-cycle valid pipe plus data hold register, with a forward-select input for the optional feature.
- The arbiter/FSM stays in the top module.

Test Plan:
- Reset -> ram_csb0_o = ram_csb1_o = 1, rd_valid_o = 0, rd_data_o = 0; then write addr 3 = 0xDEAD_BEEF_0000_0001, next cycle read addr 3 -> rd_accept_o = 1 and one cycle later rd_valid_o = 1 with rd_data_o = 0xDEAD_BEEF_0000_0001, held on the following idle cycles.
- Same-cycle wr addr 7 and rd addr 7 -> wr_accept_o = 1 and rd_accept_o = 0.
  - Retry next cycle -> new data returned.
  - With ICACHE_RAM_ARB_FWD_EN defined, rd_accept_o = 1 in the collision cycle and rd_data_o = the write data one cycle later.
- Same-cycle wr addr 1 and rd addr 2 -> both accepted; read returns the old contents of addr 2.
- flush_i pulse -> flush_busy_o high for exactly 32 cycles, addresses 0..31 written with FLUSH_VALUE, flush_done_o for 1 cycle; requests during the sweep get accept = 0; reading addr 31 afterwards returns 0.
- rst_i asserted at flush counter = 10 -> outputs return to reset values immediately, no flush_done_o; a new flush_i then completes a full 32-cycle sweep.
